// File: rtl/fft_pkg.sv
// Shared types and constants for the 8-point FFT core and the controllers that feed it.
// Frames are eight {real, imag} Q8.8 points, point 0 in the least significant word.
package fft_pkg;

    localparam int unsigned POINT_W  = 16;
    localparam int unsigned N_POINTS = 8;
    localparam int unsigned FRAME_W  = 2 * POINT_W * N_POINTS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESULT
    } state_t;

    typedef logic [2*POINT_W-1:0] point_t;

    function automatic point_t pack_point(input logic [POINT_W-1:0] re,
                                          input logic [POINT_W-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [POINT_W-1:0] point_re(input point_t p);
        return p[2*POINT_W-1:POINT_W];
    endfunction

    function automatic logic [POINT_W-1:0] point_im(input point_t p);
        return p[POINT_W-1:0];
    endfunction

    function automatic point_t get_point(input logic [FRAME_W-1:0] f,
                                         input int unsigned        k);
        return f[k*2*POINT_W +: 2*POINT_W];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping,
// and returns the first active requester as one-hot and as an index.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     winner_oh,
    output logic [IDX_W-1:0] winner_idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_oh  = '0;
        winner_idx = '0;
        valid      = 1'b0;
        cand       = '0;
        // i = N revisits last itself, so a lone requester can win back to back
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IDX_W'((32'(last) + i) % N);
            if (!valid && req[cand]) begin
                valid           = 1'b1;
                winner_oh[cand] = 1'b1;
                winner_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/fft_scheduler.sv
// Shares one 8-point FFT core among NUM_REQ requesters: round-robin grant, frame
// load, start/ready handshake with timeout, and a tagged registered result.
module fft_scheduler
    import fft_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    parameter  int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*FRAME_W-1:0] req_frame,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [FRAME_W-1:0]         fft_frame,
    output logic                       fft_write,
    output logic                       fft_start,
    input  logic                       fft_ready,
    input  logic [FRAME_W-1:0]         fft_result,
    output logic                       res_valid,
    output logic [ID_W-1:0]            res_id,
    output logic [FRAME_W-1:0]         res_frame,
    input  logic                       res_ack,
    output logic                       busy,
    output logic                       timeout_err,
    output logic [15:0]                frames_done
);

    localparam int unsigned       CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_q;
    logic [ID_W-1:0]     cur_id_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [FRAME_W-1:0]  fft_frame_q;
    logic [FRAME_W-1:0]  res_frame_q;
    logic [ID_W-1:0]     res_id_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [15:0]         frames_done_q, frames_done_d;
    logic                timeout_err_q;

    logic [NUM_REQ-1:0]  arb_oh;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_valid;
    logic                take_grant;
    logic                wait_done;
    logic                wait_expired;
    logic [FRAME_W-1:0]  frame_slot [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
        assign frame_slot[g] = req_frame[g*FRAME_W +: FRAME_W];
    end

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req        (req),
        .last       (last_q),
        .winner_oh  (arb_oh),
        .winner_idx (arb_idx),
        .valid      (arb_valid)
    );

    assign take_grant   = (state_q == IDLE) && arb_valid;
    assign wait_done    = (state_q == WAIT) && fft_ready;
    // ready in the final timeout cycle still counts as completion
    assign wait_expired = (state_q == WAIT) && !fft_ready && (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = LOAD;
            LOAD:    state_d = START;
            START:   state_d = WAIT;
            WAIT: begin
                if (fft_ready) begin
                    state_d = RESULT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            RESULT:  if (res_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt       = '0;
        fft_write = 1'b0;
        fft_start = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE:  busy = 1'b0;
            LOAD: begin
                gnt       = gnt_q;
                fft_write = 1'b1;
            end
            START: begin
                fft_write = 1'b1;
                fft_start = 1'b1;
            end
            WAIT:    fft_start = 1'b1;
            RESULT:  res_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d         = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
        frames_done_d = wait_done ? frames_done_q + 16'd1 : frames_done_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_q        <= ID_W'(NUM_REQ - 1);
            cur_id_q      <= '0;
            gnt_q         <= '0;
            fft_frame_q   <= '0;
            res_frame_q   <= '0;
            res_id_q      <= '0;
            cnt_q         <= '0;
            frames_done_q <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frames_done_q <= frames_done_d;
            timeout_err_q <= wait_expired;
            if (take_grant) begin
                fft_frame_q <= frame_slot[arb_idx];
                cur_id_q    <= arb_idx;
                last_q      <= arb_idx;
                gnt_q       <= arb_oh;
            end
            if (wait_done) begin
                res_frame_q <= fft_result;
                res_id_q    <= cur_id_q;
            end
        end
    end

    assign fft_frame   = fft_frame_q;
    assign res_frame   = res_frame_q;
    assign res_id      = res_id_q;
    assign frames_done = frames_done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fft_scheduler.sv
// Scoreboard bench for fft_scheduler with a behavioural stand-in for the FFT core.
module tb_fft_scheduler;
    import fft_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 64;

    localparam logic [255:0] RAMP = {
        32'h0700_0000, 32'h0600_0000, 32'h0500_0000, 32'h0400_0000,
        32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
    // 8-point DFT of the ramp 0..7, unscaled Q8.8, rounded to nearest
    localparam logic [255:0] DFT_RAMP = {
        32'hFC00_F658, 32'hFC00_FC00, 32'hFC00_FE58, 32'hFC00_0000,
        32'hFC00_01A8, 32'hFC00_0400, 32'hFC00_09A8, 32'h1C00_0000};
    localparam logic [255:0] XMASK = {8{32'h5A5A_A5A5}};

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NREQ-1:0]         req;
    logic [NREQ*256-1:0]     req_frame;
    logic [NREQ-1:0]         gnt;
    logic [255:0]            fft_frame;
    logic                    fft_write;
    logic                    fft_start;
    logic                    fft_ready;
    logic [255:0]            fft_result;
    logic                    res_valid;
    logic [1:0]              res_id;
    logic [255:0]            res_frame;
    logic                    res_ack;
    logic                    busy;
    logic                    timeout_err;
    logic [15:0]             frames_done;

    fft_scheduler #(
        .NUM_REQ (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .req_frame   (req_frame),
        .gnt         (gnt),
        .fft_frame   (fft_frame),
        .fft_write   (fft_write),
        .fft_start   (fft_start),
        .fft_ready   (fft_ready),
        .fft_result  (fft_result),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_frame   (res_frame),
        .res_ack     (res_ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .frames_done (frames_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]   id;
        logic [255:0] frame;
        logic [15:0]  done;
    } exp_t;

    exp_t            sb[$];
    logic [NREQ-1:0] gnt_log[$];
    int              checks = 0;
    int              errors = 0;
    int              n_results = 0;
    int              n_timeouts = 0;
    int              ready_at = -1;
    int              scnt = 0;
    logic            rv_prev = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Core stand-in: known golden answer for the ramp, a fixed XOR otherwise
    function automatic logic [255:0] core_model(input logic [255:0] f);
        if (f == RAMP) return DFT_RAMP;
        return f ^ XMASK;
    endfunction

    function automatic logic [255:0] slot(input int i);
        return req_frame[i*256 +: 256];
    endfunction

    always_comb fft_result = core_model(fft_frame);

    // ready rises ready_at WAIT cycles after WAIT entry (START is scnt==1)
    always @(negedge CLK) begin
        if (fft_start) scnt = scnt + 1;
        else           scnt = 0;
        fft_ready = (ready_at >= 0) && (scnt == ready_at + 2);
    end

    always @(negedge CLK) begin
        exp_t e;
        if (res_valid && !rv_prev) begin
            n_results++;
            if (sb.size() == 0) begin
                chk("unexpected_result", 256'(res_id), 256'(4'hF));
            end else begin
                e = sb.pop_front();
                chk("res_id", 256'(res_id), 256'(e.id));
                chk("res_frame", res_frame, e.frame);
                chk("frames_done", 256'(frames_done), 256'(e.done));
            end
        end
        if (timeout_err) n_timeouts++;
        if (gnt != '0) gnt_log.push_back(gnt);
        rv_prev <= res_valid;
    end

    task automatic wait_valid(input int maxc, output int n);
        n = 0;
        while (!res_valid && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        if (!res_valid) chk("wait_res_valid", 256'(res_valid), 256'(1));
    endtask

    task automatic push_exp(input int id, input int done);
        exp_t e;
        e.id    = 2'(id);
        e.frame = core_model(slot(id));
        e.done  = 16'(done);
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        int t0;
        int r0;
        logic ok;

        RST = 1'b1; req = '0; req_frame = '0; res_ack = 1'b0; fft_ready = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_ctrl", 256'({gnt, fft_write, fft_start, res_valid, busy, timeout_err, res_id}), 256'(0));
        chk("reset_frames_done", 256'(frames_done), 256'(0));
        chk("reset_res_frame", res_frame, 256'(0));
        RST = 1'b0;

        // Single request with the ramp frame
        req_frame[255:0] = RAMP;
        ready_at = 3; res_ack = 1'b1;
        @(negedge CLK);
        req = 4'b0001;
        push_exp(0, 1);
        @(negedge CLK);
        chk("t1_gnt", 256'(gnt), 256'(4'b0001));
        chk("t1_write_load", 256'({fft_write, fft_start}), 256'(2'b10));
        chk("t1_fft_frame", fft_frame, RAMP);
        req = '0;
        @(negedge CLK);
        chk("t1_start", 256'({gnt, fft_write, fft_start}), 256'(6'b0000_11));
        @(negedge CLK);
        chk("t1_wait", 256'({fft_write, fft_start}), 256'(2'b01));
        wait_valid(20, n);
        chk("t1_latency", 256'(n + 3), 256'(7));
        @(negedge CLK);
        chk("t1_idle", 256'({busy, res_valid}), 256'(0));

        // Contention from reset: all four requesting, results acked immediately
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int p = 0; p < 8; p++)
                req_frame[i*256 + p*32 +: 32] = {16'(i*256 + p), 16'(32'h8000 + p*3)};
        gnt_log.delete();
        for (int j = 0; j < 8; j++) push_exp(j % 4, j + 1);
        ready_at = 0;
        req = 4'b1111;
        n = 0; k = 0;
        while (n < 8 && k < 200) begin
            @(negedge CLK);
            k++;
            if (res_valid) n++;
        end
        req = '0;
        chk("t2_results", 256'(n), 256'(8));
        repeat (3) @(negedge CLK);
        chk("t2_grants", 256'(gnt_log.size()), 256'(8));
        for (int j = 0; j < 8 && j < gnt_log.size(); j++)
            chk("t2_rotation", 256'(gnt_log[j]), 256'(4'b0001 << (j % 4)));

        // Timeout with ready stuck low
        ready_at = -1;
        t0 = n_timeouts; r0 = n_results;
        req = 4'b0100;
        @(negedge CLK);
        chk("t3_gnt", 256'(gnt), 256'(4'b0100));
        req = '0;
        @(negedge CLK);
        @(negedge CLK);
        k = 0;
        while (!timeout_err && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("t3_timeout_cycle", 256'(k), 256'(TMO));
        chk("t3_abort_state", 256'({busy, fft_start, fft_write}), 256'(0));
        @(negedge CLK);
        chk("t3_pulse_width", 256'(timeout_err), 256'(0));
        chk("t3_pulse_count", 256'(n_timeouts - t0), 256'(1));
        chk("t3_no_result", 256'(n_results - r0), 256'(0));
        chk("t3_frames_done", 256'(frames_done), 256'(8));

        // Ready arrives in the last permitted WAIT cycle
        ready_at = TMO - 1;
        t0 = n_timeouts;
        req = 4'b0001;
        push_exp(0, 9);
        @(negedge CLK);
        req = '0;
        @(negedge CLK);
        @(negedge CLK);
        wait_valid(100, n);
        chk("t4_collision_cycle", 256'(n), 256'(TMO));
        repeat (2) @(negedge CLK);
        chk("t4_no_timeout", 256'(n_timeouts - t0), 256'(0));

        // Backpressure with requester 1 pending
        ready_at = 0; res_ack = 1'b0;
        req = 4'b0001;
        push_exp(0, 10);
        wait_valid(20, n);
        req = 4'b0010;
        ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (!res_valid || res_frame !== core_model(slot(0)) || res_id !== 2'd0 || gnt !== '0)
                ok = 1'b0;
        end
        chk("t5_stable", 256'(ok), 256'(1));
        res_ack = 1'b1;
        push_exp(1, 11);
        @(negedge CLK);
        res_ack = 1'b0;
        chk("t5_bubble", 256'({gnt, busy}), 256'(0));
        @(negedge CLK);
        chk("t5_gnt", 256'(gnt), 256'(4'b0010));
        req = '0; res_ack = 1'b1;
        wait_valid(20, n);
        repeat (2) @(negedge CLK);

        // Asynchronous reset in the middle of WAIT
        ready_at = -1;
        req = 4'b0001;
        @(negedge CLK);
        req = '0;
        repeat (4) @(negedge CLK);
        chk("t6_in_wait", 256'(fft_start), 256'(1));
        #2 RST = 1'b1;
        #1;
        chk("t6_async_ctrl", 256'({gnt, fft_write, fft_start, res_valid, busy, timeout_err, res_id}), 256'(0));
        chk("t6_async_data", 256'({fft_frame, frames_done}), 256'(0));
        @(negedge CLK);
        RST = 1'b0;
        req = 4'b0110;
        @(negedge CLK);
        chk("t6_first_gnt", 256'(gnt), 256'(4'b0010));
        req = '0; ready_at = 0;
        push_exp(1, 1);
        wait_valid(20, n);
        repeat (3) @(negedge CLK);

        chk("scoreboard_empty", 256'(sb.size()), 256'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
